drp_arbiter: RTL and testbench
==============================

DRP_ARBITER -- requirements
Module: drp_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of DRP requesters, range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 64: max cycles waiting for drp_rdy, range 2..255.
REQ-003 Port clk, input, 1: DRP clock; the block's only clock.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, NUM_REQ: per-requester transaction request, level, held until ack.
REQ-006 Port req_we, input, NUM_REQ: per-requester write flag (1 = write, 0 = read).
REQ-007 Port req_addr, input, 8*NUM_REQ: packed per-requester DRP address, slice i = [8i+7:8i].
REQ-008 Port req_di, input, 16*NUM_REQ: packed per-requester write data, slice i = [16i+15:16i].
REQ-009 Port ack, output, NUM_REQ: one-hot, one-cycle completion pulse to the granted requester.
REQ-010 Port ack_err, output, 1: qualifies ack; 1 = transaction timed out.
REQ-011 Port rdata, output, 16: read data, valid in the ack cycle.
REQ-012 Port busy, output, 1: high whenever state is not IDLE.
REQ-013 Ports drp_en, drp_we (output, 1), drp_addr (output, 8), drp_di (output, 16): DRP master controls.
REQ-014 Ports drp_rdy (input, 1), drp_do (input, 16): DRP completion and read data.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_RDY, RESP.
REQ-016 IDLE: if any req bit is set, latch the round-robin winner index, its we/addr/di; go to ISSUE. Otherwise stay.
REQ-017 Round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates on grant; after reset last_grant = NUM_REQ-1, so requester 0 wins first.
REQ-018 ISSUE: drive drp_en = 1 for exactly one cycle with latched drp_we/drp_addr/drp_di; go to WAIT_RDY.
REQ-019 drp_addr, drp_we and drp_di SHALL hold latched values from ISSUE through RESP.
REQ-020 WAIT_RDY: on drp_rdy, capture drp_do into rdata (reads only; writes leave rdata unchanged); go to RESP.
REQ-021 RESP: assert ack[winner] for one cycle with ack_err as determined; return to IDLE.
REQ-022 Minimum latency from req sampled in IDLE to ack = 3 cycles plus DRP wait cycles; back-to-back grants SHALL NOT overlap.
REQ-023 drp_rdy in any state other than WAIT_RDY SHALL be ignored.
REQ-024 A requester deasserting req after grant SHALL NOT abort the transaction; ack is still issued.
REQ-025 Requests arriving while busy SHALL be held off and considered at the next IDLE cycle.

Reset
REQ-026 On rst: state = IDLE, drp_en = 0, drp_we = 0, drp_addr = 0, drp_di = 0, rdata = 0, ack = 0, ack_err = 0, busy = 0, timeout counter = 0, last_grant = NUM_REQ-1.
REQ-027 rst mid-transaction SHALL abandon it without issuing ack; a late drp_rdy after reset is ignored.

Configuration
REQ-028 Macro DRP_ARB_TIMEOUT_EN defined: 8-bit counter cleared in ISSUE, incremented each WAIT_RDY cycle; on reaching TIMEOUT_CYC without drp_rdy, go to RESP with ack_err = 1 and rdata unchanged.
REQ-029 Macro undefined: no counter; WAIT_RDY waits indefinitely; ack_err is tied to 0.
REQ-030 drp_rdy in the same cycle the timeout is reached SHALL count as success (ack_err = 0).

Structure
REQ-031 Shared package drp_pkg SHALL hold the FSM state encoding, DRP_ADDR_W = 8, DRP_DATA_W = 16.
REQ-032 The round-robin winner selection SHALL be a sub-module rr_arbiter (inputs req, last_grant; output winner index plus valid).

Verification
REQ-033 Single read: req[0], addr 0x4F; drp_rdy 2 cycles after drp_en with drp_do 0xA5C3 -> one drp_en pulse with drp_we = 0, ack = 0001, rdata = 0xA5C3, ack_err = 0.
REQ-034 All four requesters held continuously -> grant order 0,1,2,3,0; each drp_en separated by a full transaction.
REQ-035 Write by req[2]: addr 0x10, di 0x1234 -> drp_we = 1, drp_di = 0x1234, ack = 0100, rdata unchanged.
REQ-036 DRP_ARB_TIMEOUT_EN defined, TIMEOUT_CYC = 8, drp_rdy never asserted -> ack with ack_err = 1 eight WAIT_RDY cycles after ISSUE; next request served normally.
REQ-037 rst asserted during WAIT_RDY, then drp_rdy pulsed -> no ack; all outputs at reset values; next grant goes to requester 0.
REQ-038 drp_rdy pulsed while IDLE with no req -> no state change, no ack.

Source files
------------

// File: rtl/drp_pkg.sv
// ----------------------------------------------------------------------------
// drp_pkg
// Shared definitions for the DRP arbiter slice: DRP bus widths and the
// arbiter FSM state encoding.
// ----------------------------------------------------------------------------
package drp_pkg;

    localparam int DRP_ADDR_W = 8;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2,
        RESP     = 2'd3
    } drp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin winner selection. The search starts at the
// requester after last_grant and wraps modulo NUM_REQ.
//
// Ports:
//   req        in  [NUM_REQ-1:0]  request vector
//   last_grant in  [IDX_W-1:0]    index granted most recently
//   winner     out [IDX_W-1:0]    selected requester index
//   valid      out                at least one request is pending
// ----------------------------------------------------------------------------
module rr_arbiter
    import drp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // One extra bit so last_grant + offset never overflows before the wrap.
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest pending
    // requester after last_grant is the one left standing.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last_grant} + SUM_W'(i);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                winner = cand[IDX_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drp_arbiter.sv
// ----------------------------------------------------------------------------
// drp_arbiter
// Round-robin arbiter sharing one DRP master port among NUM_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT_RDY -> RESP -> IDLE.
//
// Optional feature macro: DRP_ARB_TIMEOUT_EN
//   defined   : WAIT_RDY gives up after TIMEOUT_CYC cycles and acks with
//               ack_err = 1.
//   undefined : WAIT_RDY waits indefinitely, ack_err is constant 0.
//
// Ports:
//   clk, rst              DRP clock, synchronous active-high reset
//   req, req_we           per-requester request level and write flag
//   req_addr, req_di      packed per-requester address / write data
//   ack, ack_err          one-hot completion pulse and its error qualifier
//   rdata                 read data, valid in the ack cycle
//   busy                  high whenever the FSM is not IDLE
//   drp_en, drp_we,
//   drp_addr, drp_di      DRP master controls
//   drp_rdy, drp_do       DRP completion strobe and read data
// ----------------------------------------------------------------------------
module drp_arbiter
    import drp_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [DRP_ADDR_W*NUM_REQ-1:0]  req_addr,
    input  logic [DRP_DATA_W*NUM_REQ-1:0]  req_di,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           ack_err,
    output logic [DRP_DATA_W-1:0]          rdata,
    output logic                           busy,
    output logic                           drp_en,
    output logic                           drp_we,
    output logic [DRP_ADDR_W-1:0]          drp_addr,
    output logic [DRP_DATA_W-1:0]          drp_di,
    input  logic                           drp_rdy,
    input  logic [DRP_DATA_W-1:0]          drp_do
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_param_check
        $error("drp_arbiter: NUM_REQ or TIMEOUT_CYC out of range");
    end

    drp_state_t             state;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       winner;
    logic                   win_valid;

    logic [DRP_ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DRP_DATA_W-1:0]  di_arr   [NUM_REQ];

    // Unpack the flat request buses so the winner index can select directly.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*DRP_ADDR_W +: DRP_ADDR_W];
        assign di_arr[g]   = req_di[g*DRP_DATA_W +: DRP_DATA_W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .valid      (win_valid)
    );

`ifdef DRP_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] timeout_cnt;
    logic       ack_err_q;

    assign ack_err = ack_err_q;
`else
    assign ack_err = 1'b0;
`endif

    // Main FSM. Outputs are registered on the transition into the state in
    // which they are visible, so drp_en is high exactly while in ISSUE, ack
    // exactly while in RESP and busy whenever the state is not IDLE. The
    // latched drp_we/addr/di stay put until the next grant, which keeps them
    // stable from ISSUE through RESP. drp_rdy is looked at only in WAIT_RDY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            drp_en     <= 1'b0;
            drp_we     <= 1'b0;
            drp_addr   <= '0;
            drp_di     <= '0;
            rdata      <= '0;
            ack        <= '0;
            busy       <= 1'b0;
`ifdef DRP_ARB_TIMEOUT_EN
            timeout_cnt <= '0;
            ack_err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant_idx  <= winner;
                        last_grant <= winner;
                        drp_we     <= req_we[winner];
                        drp_addr   <= addr_arr[winner];
                        drp_di     <= di_arr[winner];
                        drp_en     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    drp_en <= 1'b0;
                    state  <= WAIT_RDY;
`ifdef DRP_ARB_TIMEOUT_EN
                    timeout_cnt <= '0;
`endif
                end
                WAIT_RDY: begin
                    // A ready arriving on the last allowed cycle still wins.
                    if (drp_rdy) begin
                        if (!drp_we) begin
                            rdata <= drp_do;
                        end
                        ack   <= ACK_ONE << grant_idx;
                        state <= RESP;
`ifdef DRP_ARB_TIMEOUT_EN
                        ack_err_q <= 1'b0;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        ack       <= ACK_ONE << grant_idx;
                        ack_err_q <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
`endif
                    end
                end
                RESP: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef DRP_ARB_TIMEOUT_EN
                    ack_err_q <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drp_arbiter.sv
// ----------------------------------------------------------------------------
// tb_drp_arbiter
// Directed bench for drp_arbiter with a small DRP slave model and a
// scoreboard of expected transactions. Expectations are queued when a
// request is raised and compared when the matching ack is observed.
// ----------------------------------------------------------------------------
module tb_drp_arbiter;

    localparam int NREQ   = 4;
    localparam int TO_CYC = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_we;
    logic [8*NREQ-1:0] req_addr;
    logic [16*NREQ-1:0] req_di;
    logic [NREQ-1:0]   ack;
    logic              ack_err;
    logic [15:0]       rdata;
    logic              busy;
    logic              drp_en;
    logic              drp_we;
    logic [7:0]        drp_addr;
    logic [15:0]       drp_di;
    logic              drp_rdy;
    logic [15:0]       drp_do;

    drp_arbiter #(
        .NUM_REQ     (NREQ),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_di   (req_di),
        .ack      (ack),
        .ack_err  (ack_err),
        .rdata    (rdata),
        .busy     (busy),
        .drp_en   (drp_en),
        .drp_we   (drp_we),
        .drp_addr (drp_addr),
        .drp_di   (drp_di),
        .drp_rdy  (drp_rdy),
        .drp_do   (drp_do)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] di;
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] di;
        int          cyc;
    } en_t;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic            err;
        logic [15:0]     rdata;
        logic            we;
        logic [7:0]      addr;
        logic [15:0]     di;
        int              cyc;
    } ack_t;

    exp_t exp_q[$];
    en_t  en_log[$];
    ack_t ack_log[$];

    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    logic [15:0] model_rdata = 16'h0000;
    logic [15:0] rd_mem [256];

    int          slave_delay = 2;
    bit          slave_on    = 1'b1;
    bit          force_rdy   = 1'b0;
    int          slave_cnt   = 0;
    logic [7:0]  slave_addr  = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every drp_en cycle and every ack cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (drp_en === 1'b1) begin
            en_log.push_back('{drp_we, drp_addr, drp_di, cyc});
        end
        if (ack !== '0) begin
            ack_log.push_back('{ack, ack_err, rdata, drp_we, drp_addr, drp_di, cyc});
        end
    end

    // DRP slave: answers slave_delay cycles after drp_en with rd_mem data.
    always @(negedge clk) begin
        drp_rdy = 1'b0;
        drp_do  = 16'hDEAD;
        if (slave_cnt > 0) begin
            slave_cnt = slave_cnt - 1;
            if (slave_cnt == 0) begin
                drp_rdy = 1'b1;
                drp_do  = rd_mem[slave_addr];
            end
        end
        if (force_rdy) begin
            drp_rdy   = 1'b1;
            drp_do    = 16'hBEEF;
            force_rdy = 1'b0;
        end
        if (drp_en === 1'b1 && slave_on) begin
            slave_cnt  = slave_delay;
            slave_addr = drp_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        req = '0;
        stepCycles(3);
        rst = 1'b0;
        model_rdata = 16'h0000;
        stepCycles(1);
    endtask

    task automatic checkResetState(input string pfx);
        chk({pfx, "_ack"},      32'(ack),      32'h0);
        chk({pfx, "_ack_err"},  32'(ack_err),  32'h0);
        chk({pfx, "_busy"},     32'(busy),     32'h0);
        chk({pfx, "_drp_en"},   32'(drp_en),   32'h0);
        chk({pfx, "_drp_we"},   32'(drp_we),   32'h0);
        chk({pfx, "_drp_addr"}, 32'(drp_addr), 32'h0);
        chk({pfx, "_drp_di"},   32'(drp_di),   32'h0);
        chk({pfx, "_rdata"},    32'(rdata),    32'h0);
    endtask

    task automatic setReq(input int idx, input logic we, input logic [7:0] addr, input logic [15:0] di);
        req_we[idx]             = we;
        req_addr[idx*8 +: 8]    = addr;
        req_di[idx*16 +: 16]    = di;
        req[idx]                = 1'b1;
    endtask

    // Queue the expected outcome of requester idx with its current request.
    task automatic expectTxn(input int idx, input logic err);
        exp_t e;
        e.idx  = idx;
        e.we   = req_we[idx];
        e.addr = req_addr[idx*8 +: 8];
        e.di   = req_di[idx*16 +: 16];
        if (!e.we && !err) model_rdata = rd_mem[e.addr];
        e.rdata = model_rdata;
        e.err   = err;
        e.lat   = err ? TO_CYC + 1 : slave_delay + 1;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input int idx, input logic we, input logic [7:0] addr,
                                 input logic [15:0] di, input logic err);
        setReq(idx, we, addr, di);
        expectTxn(idx, err);
    endtask

    task automatic checkOutput(input bit drop, output int en_cyc, output int ack_cyc);
        exp_t e;
        en_t  en;
        ack_t a;
        en_cyc  = -1;
        ack_cyc = -1;
        chk("exp_queue_nonempty", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int k = 0; k < 60 && ack_log.size() == 0; k++) begin
            @(negedge clk);
            #1;
        end
        chk("ack_seen", 32'(ack_log.size() > 0), 32'h1);
        if (ack_log.size() == 0) return;
        a = ack_log.pop_front();
        ack_cyc = a.cyc;
        chk("ack_onehot",   32'(a.ack),   32'(1 << e.idx));
        chk("ack_err",      32'(a.err),   32'(e.err));
        chk("rdata",        32'(a.rdata), 32'(e.rdata));
        chk("resp_drp_we",  32'(a.we),    32'(e.we));
        chk("resp_drp_addr", 32'(a.addr), 32'(e.addr));
        chk("resp_drp_di",  32'(a.di),    32'(e.di));
        chk("drp_en_pulses", 32'(en_log.size()), 32'h1);
        if (en_log.size() > 0) begin
            en = en_log.pop_front();
            en_cyc = en.cyc;
            chk("issue_drp_we",   32'(en.we),   32'(e.we));
            chk("issue_drp_addr", 32'(en.addr), 32'(e.addr));
            chk("issue_drp_di",   32'(en.di),   32'(e.di));
            chk("en_to_ack_cycles", 32'(a.cyc - en.cyc), 32'(e.lat));
            en_log.delete();
        end
        if (drop) req[e.idx] = 1'b0;
    endtask

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int en_c, ack_c, prev_ack;
        int order [5];

        for (int i = 0; i < 256; i++) rd_mem[i] = 16'(i * 257) ^ 16'h5A5A;
        rd_mem[8'h4F] = 16'hA5C3;

        rst      = 1'b1;
        req      = '0;
        req_we   = '0;
        req_addr = '0;
        req_di   = '0;
        drp_rdy  = 1'b0;
        drp_do   = 16'h0000;

        $display("[TB] reset");
        resetDut();
        checkResetState("reset");

        $display("[TB] drp_rdy while idle");
        force_rdy = 1'b1;
        stepCycles(3);
        chk("idle_rdy_busy",   32'(busy),           32'h0);
        chk("idle_rdy_no_ack", 32'(ack_log.size()), 32'h0);
        chk("idle_rdy_no_en",  32'(en_log.size()),  32'h0);
        chk("idle_rdy_rdata",  32'(rdata),          32'h0);

        $display("[TB] single read by requester 0");
        slave_delay = 2;
        applyStimulus(0, 1'b0, 8'h4F, 16'h0000, 1'b0);
        checkOutput(1'b1, en_c, ack_c);
        stepCycles(2);

        $display("[TB] write by requester 2");
        applyStimulus(2, 1'b1, 8'h10, 16'h1234, 1'b0);
        checkOutput(1'b1, en_c, ack_c);
        stepCycles(2);

        $display("[TB] all requesters held");
        resetDut();
        slave_delay = 1;
        order = '{0, 1, 2, 3, 0};
        setReq(0, 1'b0, 8'h21, 16'h0000);
        setReq(1, 1'b1, 8'h42, 16'hBEAD);
        setReq(2, 1'b0, 8'h63, 16'h0000);
        setReq(3, 1'b0, 8'h84, 16'h0000);
        for (int i = 0; i < 5; i++) expectTxn(order[i], 1'b0);
        prev_ack = -1;
        for (int i = 0; i < 5; i++) begin
            checkOutput(1'b0, en_c, ack_c);
            if (prev_ack >= 0) chk("grant_gap", 32'(en_c - prev_ack), 32'h2);
            prev_ack = ack_c;
        end
        req = '0;
        stepCycles(4);
        chk("held_no_extra_en",  32'(en_log.size()),  32'h0);
        chk("held_no_extra_ack", 32'(ack_log.size()), 32'h0);

`ifdef DRP_ARB_TIMEOUT_EN
        $display("[TB] timeout then normal request");
        slave_on = 1'b0;
        applyStimulus(1, 1'b0, 8'h22, 16'h0000, 1'b1);
        checkOutput(1'b1, en_c, ack_c);
        stepCycles(2);
        slave_on    = 1'b1;
        slave_delay = 3;
        applyStimulus(3, 1'b0, 8'h33, 16'h0000, 1'b0);
        checkOutput(1'b1, en_c, ack_c);
        stepCycles(2);
`endif

        $display("[TB] reset during WAIT_RDY");
        slave_on = 1'b0;
        setReq(2, 1'b0, 8'h55, 16'h0000);
        for (int k = 0; k < 20 && en_log.size() == 0; k++) stepCycles(1);
        chk("pre_rst_en_seen", 32'(en_log.size() > 0), 32'h1);
        stepCycles(2);
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        req = '0;
        model_rdata = 16'h0000;
        force_rdy = 1'b1;
        stepCycles(3);
        chk("rst_no_ack", 32'(ack_log.size()), 32'h0);
        checkResetState("post_rst");
        en_log.delete();
        slave_on    = 1'b1;
        slave_delay = 2;
        setReq(1, 1'b0, 8'h66, 16'h0000);
        setReq(2, 1'b0, 8'h77, 16'h0000);
        setReq(3, 1'b1, 8'h88, 16'h9999);
        applyStimulus(0, 1'b0, 8'h4F, 16'h0000, 1'b0);
        checkOutput(1'b0, en_c, ack_c);
        req = '0;
        stepCycles(4);
        chk("post_rst_single_grant", 32'(ack_log.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
